// File: rtl/multi_counter.sv
// rtl/multi_counter.sv - bank of signed up/down counters with per-channel compare and sticky overflow
module multi_counter #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [$clog2(CHANNELS)-1:0] ch_sel,
    input  logic                        load,
    input  logic                        increment,
    input  logic                        decrement,
    input  logic [WIDTH-1:0]            data,
    input  logic [WIDTH-1:0]            step,
    input  logic                        cmp_load,
    input  logic                        clear_ovf,
    output logic [WIDTH-1:0]            count,
    output logic                        negative,
    output logic                        zero,
    output logic                        positive,
    output logic [CHANNELS-1:0]         ovf,
    output logic [CHANNELS-1:0]         match
);

    localparam int SEL_W = $clog2(CHANNELS);
    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]    count_q [CHANNELS];
    logic [WIDTH-1:0]    cmp_q   [CHANNELS];
    logic [WIDTH-1:0]    count_d [CHANNELS];
    logic [WIDTH-1:0]    cmp_d   [CHANNELS];
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic [CHANNELS-1:0] match_q, match_d;

    logic             sel_valid;
    logic [SEL_W-1:0] sel_idx;
    logic [WIDTH-1:0] cur;
    logic             up, down, overflow, hit;
    logic [WIDTH+1:0] ext_cur, ext_step, result;
    logic [WIDTH-1:0] new_val;

    assign sel_valid = int'(ch_sel) < CHANNELS;
    assign sel_idx   = sel_valid ? ch_sel : '0;
    assign cur       = sel_valid ? count_q[sel_idx] : '0;

    assign count    = cur;
    assign negative = cur[WIDTH-1];
    assign zero     = (cur == '0);
    assign positive = !zero && !negative;
    assign ovf      = ovf_q;
    assign match    = match_q;

    // Two guard bits: an unsigned step of up to 2^WIDTH-1 against a signed count needs both to stay exact.
    assign up       = increment && !decrement;
    assign down     = decrement && !increment;
    assign ext_cur  = {{2{cur[WIDTH-1]}}, cur};
    assign ext_step = {2'b00, step};
    assign result   = up ? (ext_cur + ext_step) : (ext_cur - ext_step);
    assign overflow = (up || down) &&
                      (result[WIDTH+1:WIDTH-1] != 3'b000) &&
                      (result[WIDTH+1:WIDTH-1] != 3'b111);
    assign hit      = !load && overflow;

    always_comb begin
        new_val = cur;
        if (load) begin
            new_val = data;
        end else if (overflow && (SATURATE != 0)) begin
            new_val = up ? MAX_VAL : MIN_VAL;
        end else if (up || down) begin
            new_val = result[WIDTH-1:0];
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            count_d[i] = count_q[i];
            cmp_d[i]   = cmp_q[i];
            ovf_d[i]   = ovf_q[i];
            match_d[i] = 1'b0;
            if (sel_valid && (sel_idx == SEL_W'(i))) begin
                count_d[i] = new_val;
                if (cmp_load) begin
                    cmp_d[i] = data;
                end
                if (clear_ovf) begin
                    ovf_d[i] = 1'b0;
                end
                if (hit) begin
                    ovf_d[i] = 1'b1;
                end
            end
            // A hit needs an actual value change; rewriting the same value does not pulse.
            match_d[i] = (count_d[i] != count_q[i]) && (count_d[i] == cmp_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i] <= '0;
                cmp_q[i]   <= '0;
            end
            ovf_q   <= '0;
            match_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i] <= count_d[i];
                cmp_q[i]   <= cmp_d[i];
            end
            ovf_q   <= ovf_d;
            match_q <= match_d;
        end
    end

endmodule

// File: tb/tb_multi_counter.sv
// tb/tb_multi_counter.sv - randomized check of wrap (4 ch) and clamp (3 ch) counters against an integer model
module tb_multi_counter;

    logic       clk;
    logic       reset_n;
    logic [1:0] ch_sel;
    logic       load, increment, decrement, cmp_load, clear_ovf;
    logic [7:0] data, step;

    logic [7:0] count_w, count_s;
    logic       neg_w, zero_w, pos_w, neg_s, zero_s, pos_s;
    logic [3:0] ovf_w, match_w;
    logic [2:0] ovf_s, match_s;

    int total = 0;
    int bad   = 0;

    int m_cnt [2][4];
    int m_cmp [2][4];
    int m_ovf [2][4];
    int m_match [2][4];

    multi_counter #(.WIDTH(8), .CHANNELS(4), .SATURATE(0)) dut_w (
        .clk(clk), .reset_n(reset_n), .ch_sel(ch_sel), .load(load),
        .increment(increment), .decrement(decrement), .data(data), .step(step),
        .cmp_load(cmp_load), .clear_ovf(clear_ovf), .count(count_w),
        .negative(neg_w), .zero(zero_w), .positive(pos_w), .ovf(ovf_w), .match(match_w)
    );

    multi_counter #(.WIDTH(8), .CHANNELS(3), .SATURATE(1)) dut_s (
        .clk(clk), .reset_n(reset_n), .ch_sel(ch_sel), .load(load),
        .increment(increment), .decrement(decrement), .data(data), .step(step),
        .cmp_load(cmp_load), .clear_ovf(clear_ovf), .count(count_s),
        .negative(neg_s), .zero(zero_s), .positive(pos_s), .ovf(ovf_s), .match(match_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int wrap8(input int v);
        int r;
        r = ((v % 256) + 256) % 256;
        return (r >= 128) ? r - 256 : r;
    endfunction

    function automatic int to_signed8(input logic [7:0] v);
        byte b;
        b = v;
        return int'(b);
    endfunction

    // Arithmetic on mathematical integers, then the overflow rule applied to the true result.
    task automatic model_step(input int k);
        int chans, cur, n, r, sel;
        bit hit;
        chans = (k == 0) ? 4 : 3;
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[k][i] = 0; m_cmp[k][i] = 0; m_ovf[k][i] = 0; m_match[k][i] = 0;
            end
            return;
        end
        for (int i = 0; i < 4; i++) m_match[k][i] = 0;
        sel = int'(ch_sel);
        if (sel >= chans) return;
        cur = m_cnt[k][sel];
        n   = cur;
        hit = 0;
        if (load) begin
            n = to_signed8(data);
        end else if (increment != decrement) begin
            r = increment ? cur + int'(step) : cur - int'(step);
            if (r > 127 || r < -128) begin
                hit = 1;
                n = (k == 1) ? (increment ? 127 : -128) : wrap8(r);
            end else begin
                n = r;
            end
        end
        if (cmp_load) m_cmp[k][sel] = to_signed8(data);
        if (n != cur && n == m_cmp[k][sel]) m_match[k][sel] = 1;
        m_cnt[k][sel] = n;
        if (clear_ovf) m_ovf[k][sel] = 0;
        if (hit) m_ovf[k][sel] = 1;
    endtask

    function automatic int pack_bits(input int k, input int chans);
        int v;
        v = 0;
        for (int i = 0; i < chans; i++) v |= (m_ovf[k][i] << i);
        return v;
    endfunction

    function automatic int pack_match(input int k, input int chans);
        int v;
        v = 0;
        for (int i = 0; i < chans; i++) v |= (m_match[k][i] << i);
        return v;
    endfunction

    task automatic check_all();
        int sel, ew, es;
        sel = int'(ch_sel);
        ew = m_cnt[0][sel];
        es = (sel < 3) ? m_cnt[1][sel] : 0;
        check("count_w", to_signed8(count_w), ew);
        check("neg_w",   int'(neg_w),  int'(ew < 0));
        check("zero_w",  int'(zero_w), int'(ew == 0));
        check("pos_w",   int'(pos_w),  int'(ew > 0));
        check("ovf_w",   int'(ovf_w),  pack_bits(0, 4));
        check("match_w", int'(match_w), pack_match(0, 4));
        check("count_s", to_signed8(count_s), es);
        check("neg_s",   int'(neg_s),  int'(es < 0));
        check("zero_s",  int'(zero_s), int'(es == 0));
        check("pos_s",   int'(pos_s),  int'(es > 0));
        check("ovf_s",   int'(ovf_s),  pack_bits(1, 3));
        check("match_s", int'(match_s), pack_match(1, 3));
    endtask

    task automatic cycle(input bit rn, input bit [1:0] sel, input bit ld, input bit inc,
                         input bit dec, input bit [7:0] d, input bit [7:0] st,
                         input bit co, input bit cl);
        reset_n = rn; ch_sel = sel; load = ld; increment = inc; decrement = dec;
        data = d; step = st; cmp_load = co; clear_ovf = cl;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        bit [7:0] pool [8];
        bit [7:0] steps [8];
        pool  = '{8'h00, 8'h10, 8'h7E, 8'h7F, 8'h80, 8'h81, 8'hFF, 8'h0E};
        steps = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd255};

        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int s = 0; s < 4; s++) begin
            cycle(1, 2'(s), 0, 0, 0, 0, 0, 0, 0);
            check("rst_zero", int'(zero_w), 1);
        end

        cycle(1, 2, 1, 0, 0, 8'h05, 0, 0, 0);
        cycle(1, 2, 0, 1, 0, 0, 8'd3, 0, 0);
        check("inc_cnt", int'(count_w), 8'h08);
        check("inc_pos", int'(pos_w), 1);
        check("inc_ovf", int'(ovf_w), 0);

        cycle(1, 2, 1, 0, 0, 8'h7E, 0, 0, 0);
        cycle(1, 2, 0, 1, 0, 0, 8'd4, 0, 0);
        check("wrap_cnt", int'(count_w), 8'h82);
        check("wrap_neg", int'(neg_w), 1);
        check("wrap_ovf", int'(ovf_w[2]), 1);
        check("clamp_up", int'(count_s), 8'h7F);
        cycle(1, 2, 0, 0, 0, 0, 0, 0, 0);
        check("ovf_sticky", int'(ovf_w[2]), 1);
        cycle(1, 2, 0, 0, 0, 0, 0, 0, 1);
        check("ovf_clear", int'(ovf_w[2]), 0);

        cycle(1, 2, 1, 0, 0, 8'h81, 0, 0, 0);
        cycle(1, 2, 0, 0, 1, 0, 8'd5, 0, 0);
        check("clamp_dn", int'(count_s), 8'h80);
        check("clamp_ovf", int'(ovf_s[2]), 1);
        cycle(1, 2, 0, 0, 1, 0, 8'd1, 0, 0);
        check("clamp_hold", int'(count_s), 8'h80);

        cycle(1, 1, 0, 0, 0, 8'h10, 0, 1, 0);
        cycle(1, 1, 1, 0, 0, 8'h0E, 0, 0, 0);
        cycle(1, 1, 0, 1, 0, 0, 8'd1, 0, 0);
        check("match_early", int'(match_w[1]), 0);
        cycle(1, 1, 0, 1, 0, 0, 8'd1, 0, 0);
        check("match_hit", int'(match_w[1]), 1);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        check("match_gone", int'(match_w[1]), 0);

        cycle(1, 1, 1, 1, 1, 8'h33, 8'd5, 0, 0);
        check("ld_prio", int'(count_w), 8'h33);
        cycle(1, 1, 0, 1, 1, 0, 8'd200, 0, 0);
        check("incdec_cnt", int'(count_w), 8'h33);
        check("incdec_ovf", int'(ovf_w[1]), 0);

        cycle(1, 0, 1, 0, 0, 8'h7F, 0, 0, 0);
        cycle(1, 0, 0, 1, 0, 0, 8'd1, 0, 1);
        check("set_wins", int'(ovf_w[0]), 1);

        cycle(1, 3, 1, 0, 0, 8'h55, 0, 0, 0);
        check("bad_sel", int'(count_s), 0);
        cycle(1, 3, 0, 0, 0, 8'h20, 0, 1, 0);
        cycle(1, 3, 1, 0, 0, 8'h20, 0, 0, 0);
        check("match3", int'(match_w[3]), 1);
        cycle(0, 3, 0, 0, 0, 0, 0, 0, 0);
        check("rst_match", int'(match_w), 0);
        check("rst_cnt", int'(count_w), 0);

        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom % 97) != 0, 2'($urandom), ($urandom % 5) == 0,
                  ($urandom % 2) == 0, ($urandom % 3) == 0,
                  ($urandom % 4 == 0) ? 8'($urandom) : pool[$urandom % 8],
                  steps[$urandom % 8], ($urandom % 6) == 0, ($urandom % 8) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
